// File: rtl/right_barrel_shifter.sv
// right_barrel_shifter: registered 32-bit right shifter (logical/arithmetic/rotate), log-mux 16/8/4/2/1.
// Define RIGHT_BARREL_SHIFTER_PIPE_EN to register after the 16/8 stages (latency 2).
module right_barrel_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] A,
   input  logic [4:0]  shift,
   input  logic [1:0]  mode,
   output logic [31:0] B,
   output logic        out_valid
);
   // fill source: the word itself for rotate, replicated sign for arithmetic, else zero
   function automatic logic [31:0] stg(input logic [31:0] x, input int unsigned n, input logic en,
                                       input logic [1:0] m, input logic sg);
      logic [31:0] hi;
      hi = m[1] ? x : {32{m[0] & sg}};
      return en ? ((x >> n) | (hi << (32 - n))) : x;
   endfunction
   logic [31:0] b_q, b_d;
   logic        v_q, v_d;
`ifdef RIGHT_BARREL_SHIFTER_PIPE_EN
   logic [31:0] p_q, p_d;
   logic [2:0]  sh_q;
   logic [1:0]  m_q;
   logic        sg_q, pv_q;
   always_comb begin
      p_d = stg(stg(A, 16, shift[4], mode, A[31]), 8, shift[3], mode, A[31]);
      b_d = stg(stg(stg(p_q, 4, sh_q[2], m_q, sg_q), 2, sh_q[1], m_q, sg_q), 1, sh_q[0], m_q, sg_q);
      v_d = pv_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q  <= '0;
         sh_q <= '0;
         m_q  <= '0;
         sg_q <= 1'b0;
         pv_q <= 1'b0;
      end else begin
         pv_q <= in_valid;
         if (in_valid) begin
            p_q  <= p_d;
            sh_q <= shift[2:0];
            m_q  <= mode;
            sg_q <= A[31];
         end
      end
   end
`else
   always_comb begin
      b_d = stg(stg(stg(stg(stg(A, 16, shift[4], mode, A[31]), 8, shift[3], mode, A[31]),
                          4, shift[2], mode, A[31]), 2, shift[1], mode, A[31]), 1, shift[0], mode, A[31]);
      v_d = in_valid;
   end
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q <= '0;
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
         if (v_d) b_q <= b_d;
      end
   end
   assign B = b_q;
   assign out_valid = v_q;
endmodule

// File: tb/tb_right_barrel_shifter.sv
// tb_right_barrel_shifter: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_right_barrel_shifter;
`ifdef RIGHT_BARREL_SHIFTER_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] A;
   logic [4:0]  shift;
   logic [1:0]  mode;
   logic [31:0] B;
   logic        out_valid;
   int checks = 0;
   int errors = 0;

   right_barrel_shifter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .shift(shift), .mode(mode),
      .B(B), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic [1:0] m);
      if (m == 2'b00) return a >> s;
      if (m == 2'b01) return $unsigned($signed(a) >>> s);
      return (a >> s) | (a << (32 - s));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // expected outputs: latency line of (valid, result); B holds the last valid result
   logic        dv, mv;
   logic [31:0] dr, mb;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv <= 1'b0;
         dr <= '0;
         mv <= 1'b0;
         mb <= '0;
      end else begin
         dv <= in_valid;
         dr <= model(A, int'(shift), mode);
         if (LAT == 1) begin
            mv <= in_valid;
            if (in_valid) mb <= model(A, int'(shift), mode);
         end else begin
            mv <= dv;
            if (dv) mb <= dr;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("cyc_B", B, mb);
      chk("cyc_valid", {31'b0, out_valid}, {31'b0, mv});
   end

   task automatic lit(input string nm, input logic [31:0] a, input int s, input logic [1:0] m,
                      input logic [31:0] exp);
      @(negedge clk);
      A = a; shift = s[4:0]; mode = m; in_valid = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      chk(nm, B, exp);
      chk({nm, "_v"}, {31'b0, out_valid}, 32'd1);
   endtask

   logic [31:0] gap_a [4] = '{32'hF0000000, 32'hDEADBEEF, 32'h12345678, 32'h0};
   logic [4:0]  gap_s [4] = '{5'd4, 5'd5, 5'd8, 5'd0};
   logic [1:0]  gap_m [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
   logic        gap_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] gap_b [3] = '{32'h0F000000, 32'h0F000000, 32'h78123456};
   logic        gap_o [3] = '{1'b1, 1'b0, 1'b1};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A = '0; shift = '0; mode = '0;
      chk("pin_log4", model(32'h2D93FB1A, 4, 2'b00), 32'h02D93FB1);
      chk("pin_ari31", model(32'h80000000, 31, 2'b01), 32'hFFFFFFFF);
      chk("pin_rot16", model(32'h2D93FB1A, 16, 2'b11), 32'hFB1A2D93);
      chk("pin_rot0", model(32'h2D93FB1A, 0, 2'b10), 32'h2D93FB1A);
      #2;
      chk("rst_B", B, 32'h0);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         A = 32'h2D93FB1A; shift = i[4:0]; mode = 2'b00; in_valid = 1'b1;
      end
      lit("log4", 32'h2D93FB1A, 4, 2'b00, 32'h02D93FB1);
      lit("log16", 32'h2D93FB1A, 16, 2'b00, 32'h00002D93);
      lit("log31", 32'h2D93FB1A, 31, 2'b00, 32'h00000000);
      lit("ari31", 32'h80000000, 31, 2'b01, 32'hFFFFFFFF);
      lit("ari4", 32'h80000000, 4, 2'b01, 32'hF8000000);
      lit("ari4pos", 32'h2D93FB1A, 4, 2'b01, 32'h02D93FB1);
      lit("rot4_10", 32'h2D93FB1A, 4, 2'b10, 32'hA2D93FB1);
      lit("rot16_10", 32'h2D93FB1A, 16, 2'b10, 32'hFB1A2D93);
      lit("rot0_10", 32'h2D93FB1A, 0, 2'b10, 32'h2D93FB1A);
      lit("rot4_11", 32'h2D93FB1A, 4, 2'b11, 32'hA2D93FB1);
      lit("rot16_11", 32'h2D93FB1A, 16, 2'b11, 32'hFB1A2D93);
      lit("rot0_11", 32'h2D93FB1A, 0, 2'b11, 32'h2D93FB1A);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_B", B, 32'h0);
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      A = 32'h80000000; shift = 5'd4; mode = 2'b01; in_valid = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      chk("postrst_B", B, 32'hF8000000);
      chk("postrst_valid", {31'b0, out_valid}, 32'd1);
      for (int k = 0; k < 4 + LAT; k++) begin
         @(negedge clk);
         if (k < 4) begin
            A = gap_a[k]; shift = gap_s[k]; mode = gap_m[k]; in_valid = gap_v[k];
         end
         if (k >= LAT && k - LAT < 3) begin
            chk("gap_B", B, gap_b[k - LAT]);
            chk("gap_valid", {31'b0, out_valid}, {31'b0, gap_o[k - LAT]});
         end
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
